// File: rtl/aes_block_out_fifo.sv
// aes_block_out_fifo: holds whole ciphertext blocks from the encryptor and
// presents them to the I2C transmitter one byte at a time, MSB byte first.
module aes_block_out_fifo #(
  parameter int DEPTH   = 4,
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             write_enable,
  input  logic [BLOCK_W-1:0]               write_data,
  input  logic                             read_enable,
  output logic [BYTE_W-1:0]                read_data,
  output logic                             fifo_full,
  output logic                             fifo_empty,
  output logic [$clog2(DEPTH):0]           block_count,
  output logic [$clog2(BLOCK_W/BYTE_W)-1:0] byte_index,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int NB  = BLOCK_W / BYTE_W;
  localparam int BIW = $clog2(NB);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NB - 1);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [BLOCK_W-1:0] head;
  logic               wr_ok;

  // Occupancy and flags derived from the registered pointers.
  always_comb begin
    block_count = wptr - rptr;
    fifo_full   = (block_count == PW'(DEPTH));
    fifo_empty  = (block_count == '0);
    wr_ok       = write_enable && !fifo_full;
  end

  // Head byte, first-word-fall-through; forced to zero while empty.
  always_comb begin
    head      = mem[rptr[PW-2:0]];
    read_data = '0;
    if (!fifo_empty)
      read_data = head[BLOCK_W-1-BYTE_W*int'(byte_index) -: BYTE_W];
  end

  // Block storage; not reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!clear && wr_ok)
      mem[wptr[PW-2:0]] <= write_data;
  end

  // Pointers, byte cursor and sticky error flags; clear outranks read/write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      byte_index <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      byte_index <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + PW'(1);
      else if (write_enable)
        overflow <= 1'b1;
      if (read_enable) begin
        if (fifo_empty) begin
          underflow <= 1'b1;
        end else if (byte_index == LAST_BYTE) begin
          byte_index <= '0;
          rptr       <= rptr + PW'(1);
        end else begin
          byte_index <= byte_index + BIW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_block_out_fifo.sv
// Self-checking bench for aes_block_out_fifo: a queue-of-blocks model drives
// a per-cycle compare, plus literal checks on the directed scenarios.
module tb_aes_block_out_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         write_enable = 1'b0;
  logic [127:0] write_data = '0;
  logic         read_enable = 1'b0;
  logic [7:0]   read_data;
  logic         fifo_full;
  logic         fifo_empty;
  logic [2:0]   block_count;
  logic [3:0]   byte_index;
  logic         overflow;
  logic         underflow;

  aes_block_out_fifo #(.DEPTH(4), .BLOCK_W(128), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .block_count(block_count), .byte_index(byte_index),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  // Model: queue of stored blocks, index of next byte in head, sticky flags.
  logic [127:0] mq[$];
  int           mbi = 0;
  bit           mov = 1'b0;
  bit           mun = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_byte();
    logic [127:0] h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0] >> (8 * (15 - mbi));
    return h[7:0];
  endfunction

  task automatic m_reset();
    mq.delete();
    mbi = 0;
    mov = 1'b0;
    mun = 1'b0;
  endtask

  task automatic m_step(input bit we, input logic [127:0] wd, input bit re, input bit clr);
    bit was_full, was_empty, pop;
    if (clr) begin
      m_reset();
      return;
    end
    was_full  = (mq.size() == 4);
    was_empty = (mq.size() == 0);
    pop = 1'b0;
    if (re) begin
      if (was_empty) mun = 1'b1;
      else if (mbi == 15) begin pop = 1'b1; mbi = 0; end
      else mbi++;
    end
    if (we) begin
      if (was_full) mov = 1'b1;
      else mq.push_back(wd);
    end
    if (pop) void'(mq.pop_front());
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("read_data",   {120'd0, read_data},   {120'd0, m_byte()});
      chk("fifo_empty",  {127'd0, fifo_empty},  {127'd0, mq.size() == 0});
      chk("fifo_full",   {127'd0, fifo_full},   {127'd0, mq.size() == 4});
      chk("block_count", {125'd0, block_count}, 128'(mq.size()));
      chk("byte_index",  {124'd0, byte_index},  128'(mbi));
      chk("overflow",    {127'd0, overflow},    {127'd0, mov});
      chk("underflow",   {127'd0, underflow},   {127'd0, mun});
    end
  end

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic cyc(input bit we, input logic [127:0] wd, input bit re, input bit clr);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    clear        = clr;
    @(posedge clk);
    m_step(we, wd, re, clr);
    #2;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear        = 1'b0;
  endtask

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] blk;
  int           wcount;

  initial begin
    // Reset asserted before any clock edge.
    #1;
    chk("rst_empty", {127'd0, fifo_empty}, 128'd1);
    chk("rst_full",  {127'd0, fifo_full},  128'd0);
    chk("rst_count", {125'd0, block_count}, 128'd0);
    chk("rst_rdata", {120'd0, read_data},  128'd0);
    chk("rst_ovf",   {127'd0, overflow},   128'd0);
    chk("rst_unf",   {127'd0, underflow},  128'd0);
    #6;
    rst = 1'b0;
    m_reset();
    cmp_on = 1'b1;

    // Single block drained byte by byte.
    cyc(1, 128'h000102030405060708090A0B0C0D0E0F, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("seq_byte", {120'd0, read_data}, 128'(i));
      cyc(0, '0, 1, 0);
    end
    chk("seq_empty", {127'd0, fifo_empty}, 128'd1);
    chk("seq_bidx",  {124'd0, byte_index}, 128'd0);

    // Fill to full, overflow on the fifth block, drain all 64 bytes.
    for (int i = 0; i < 4; i++) cyc(1, {16{8'hA0 + 8'(i)}}, 0, 0);
    chk("fill_full",  {127'd0, fifo_full},   128'd1);
    chk("fill_count", {125'd0, block_count}, 128'd4);
    cyc(1, {16{8'hEE}}, 0, 0);
    chk("fill_ovf",   {127'd0, overflow},    128'd1);
    for (int i = 0; i < 64; i++) begin
      chk("fill_byte", {120'd0, read_data}, 128'(8'hA0 + 8'(i / 16)));
      cyc(0, '0, 1, 0);
    end

    // Full with a last-byte pop and a simultaneous write.
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, rnd_block(), 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, '0, 1, 0);
    chk("lp_bidx15", {124'd0, byte_index}, 128'd15);
    chk("lp_ovf0",   {127'd0, overflow},   128'd0);
    cyc(1, rnd_block(), 1, 0);
    chk("lp_ovf",   {127'd0, overflow},    128'd1);
    chk("lp_count", {125'd0, block_count}, 128'd3);
    chk("lp_bidx",  {124'd0, byte_index},  128'd0);
    for (int i = 0; i < 48; i++) cyc(0, '0, 1, 0);

    // Underflow, then write and clear together.
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    chk("unf_set",   {127'd0, underflow},   128'd1);
    chk("unf_count", {125'd0, block_count}, 128'd0);
    cyc(1, rnd_block(), 1, 0);
    chk("unf_wr_cnt",  {125'd0, block_count}, 128'd1);
    chk("unf_wr_bidx", {124'd0, byte_index},  128'd0);
    cyc(1, rnd_block(), 0, 1);
    chk("clr_empty", {127'd0, fifo_empty}, 128'd1);
    chk("clr_unf",   {127'd0, underflow},  128'd0);

    // Ten blocks with interleaved writes and full drains across the wrap.
    wcount = 0;
    while (wcount < 10) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n && wcount < 10; i++) begin
        cyc(1, rnd_block(), 0, 0);
        wcount++;
      end
      while (mq.size() != 0) cyc(0, '0, 1, 0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 30, rnd_block(),
          $urandom_range(0, 99) < 75, $urandom_range(0, 499) == 0);
    end

    // Asynchronous reset in the middle of a drain.
    cyc(0, '0, 0, 1);
    blk = rnd_block();
    cyc(1, blk, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0);
    chk("mid_bidx", {124'd0, byte_index}, 128'd7);
    chk("mid_byte", {120'd0, read_data},  {120'd0, blk[71:64]});
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_empty", {127'd0, fifo_empty}, 128'd1);
    chk("arst_rdata", {120'd0, read_data},  128'd0);
    chk("arst_bidx",  {124'd0, byte_index}, 128'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, rnd_block(), $urandom_range(0, 1) == 1, 0);
    for (int i = 0; i < 70; i++) cyc(0, '0, 1, 0);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
